// File: rtl/mc_luma_pbuf_if.sv
// ---------------------------------------------------------------------------
// mc_luma_pbuf_if
// Groups the signals between the luma interpolator write port, the
// downstream residual/TQ read stream and the luma prediction buffer.
//
// Signals:
//   flush_i         synchronous clear of the buffer's counters and flags
//   mc_luma_wren_i  write beat valid from the interpolator (no backpressure)
//   mc_luma_i       8 pixels of one 8x8 sub-block row, pixel 0 in LSBs
//   out_valid_o     a buffered beat is presented on the read stream
//   out_ready_i     downstream accepts the presented beat
//   out_data_o      8 pixels of one half-row, pixel 0 in LSBs
//   out_row_o       macroblock row y (0..15)
//   out_half_o      0 = columns 0-7, 1 = columns 8-15
//   out_last_o      final beat of the macroblock
//   overflow_o      one-cycle pulse after a write beat was dropped
//   drop_cnt_o      saturating dropped-beat counter (0 when not built in)
//
// Modports:
//   master  the environment side (interpolator + downstream consumer)
//   slave   the prediction buffer itself
// ---------------------------------------------------------------------------
interface mc_luma_pbuf_if #(
  parameter int BIT_DEPTH = 8
);
  logic                   flush_i;
  logic                   mc_luma_wren_i;
  logic [8*BIT_DEPTH-1:0] mc_luma_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [8*BIT_DEPTH-1:0] out_data_o;
  logic [3:0]             out_row_o;
  logic                   out_half_o;
  logic                   out_last_o;
  logic                   overflow_o;
  logic [7:0]             drop_cnt_o;

  modport master (
    output flush_i,
    output mc_luma_wren_i,
    output mc_luma_i,
    output out_ready_i,
    input  out_valid_o,
    input  out_data_o,
    input  out_row_o,
    input  out_half_o,
    input  out_last_o,
    input  overflow_o,
    input  drop_cnt_o
  );

  modport slave (
    input  flush_i,
    input  mc_luma_wren_i,
    input  mc_luma_i,
    input  out_ready_i,
    output out_valid_o,
    output out_data_o,
    output out_row_o,
    output out_half_o,
    output out_last_o,
    output overflow_o,
    output drop_cnt_o
  );
endinterface

// File: rtl/mc_luma_pbuf.sv
// ---------------------------------------------------------------------------
// mc_luma_pbuf
// Ping-pong 16x16 luma prediction buffer. The interpolator writes each
// macroblock as four 8x8 sub-blocks (TL, TR, BL, BR), eight row beats
// each. Once a bank holds a complete macroblock it is replayed in raster
// order (row y, then left/right half) over a valid/ready stream. The write
// side cannot be stalled, so a beat arriving while its target bank is still
// full is dropped and flagged.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous, active-high reset
//   bus    mc_luma_pbuf_if.slave (write beats, read stream, status)
//
// Configuration:
//   MC_LUMA_PBUF_DROP_CNT_EN  when defined, bus.drop_cnt_o is an 8-bit
//                             saturating count of dropped beats; otherwise
//                             it is tied to zero.
//
// Storage is not reset: out_data_o carries X until the first write.
// ---------------------------------------------------------------------------
module mc_luma_pbuf #(
  parameter int BIT_DEPTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  mc_luma_pbuf_if.slave bus
);

  localparam int W = 8 * BIT_DEPTH;

  // Two banks of 32 beats; entry address is {bank, b8[1:0], r[2:0]}
  logic [W-1:0] r_mem [0:63];

  logic [4:0] r_wrCnt;
  logic [4:0] r_rdCnt;
  logic       r_wrBank;
  logic       r_rdBank;
  logic [1:0] r_full;
  logic       r_overflow;

  logic       w_rdValid;
  logic       w_rdFire;
  logic       w_rdLast;
  logic       w_rdLastFire;
  logic       w_wrBypass;
  logic       w_wrAccept;
  logic       w_wrReject;
  logic       w_wrLast;
  logic [5:0] w_wrAddr;
  logic [5:0] w_rdAddr;
  logic [3:0] w_rdRow;
  logic       w_rdHalf;
  logic [1:0] w_fullNext;

  // Read side: the current beat is valid whenever the bank being drained
  // holds a complete macroblock
  assign w_rdValid    = r_full[r_rdBank];
  assign w_rdFire     = w_rdValid & bus.out_ready_i;
  assign w_rdLast     = (r_rdCnt == 5'd31);
  assign w_rdLastFire = w_rdFire & w_rdLast;

  // A write into a full bank is still allowed when that same bank is being
  // released by the final read handshake this cycle. The write lands on
  // entry 0 while the reader is on entry {y=15, half=1}, so nothing collides.
  assign w_wrBypass = w_rdLastFire & (r_rdBank == r_wrBank);
  assign w_wrAccept = bus.mc_luma_wren_i & (~r_full[r_wrBank] | w_wrBypass);
  assign w_wrReject = bus.mc_luma_wren_i & ~w_wrAccept;
  assign w_wrLast   = (r_wrCnt == 5'd31);

  // wr_cnt is already {b8, r}, so it forms the low address bits directly
  assign w_wrAddr = {r_wrBank, r_wrCnt};

  // rd_cnt is {y, half}; the source sub-block is {y[3], half}, row y[2:0]
  assign w_rdRow  = r_rdCnt[4:1];
  assign w_rdHalf = r_rdCnt[0];
  assign w_rdAddr = {r_rdBank, w_rdRow[3], w_rdHalf, w_rdRow[2:0]};

  // Full-flag update. The reader only clears the bank it drains and the
  // writer only sets the bank it fills, so applying clear then set is safe.
  always_comb begin
    w_fullNext = r_full;
    if (w_rdLastFire) begin
      w_fullNext[r_rdBank] = 1'b0;
    end
    if (w_wrAccept && w_wrLast) begin
      w_fullNext[r_wrBank] = 1'b1;
    end
  end

  // Beat storage, deliberately without reset
  always_ff @(posedge clk_i) begin
    if (w_wrAccept && !bus.flush_i) begin
      r_mem[w_wrAddr] <= bus.mc_luma_i;
    end
  end

  // Counters, bank pointers, full flags and the registered overflow pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrCnt    <= 5'd0;
      r_rdCnt    <= 5'd0;
      r_wrBank   <= 1'b0;
      r_rdBank   <= 1'b0;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
    end else if (bus.flush_i) begin
      r_wrCnt    <= 5'd0;
      r_rdCnt    <= 5'd0;
      r_wrBank   <= 1'b0;
      r_rdBank   <= 1'b0;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      r_full     <= w_fullNext;
      r_overflow <= w_wrReject;
      if (w_wrAccept) begin
        r_wrCnt <= r_wrCnt + 5'd1;
        if (w_wrLast) begin
          r_wrBank <= ~r_wrBank;
        end
      end
      if (w_rdFire) begin
        r_rdCnt <= r_rdCnt + 5'd1;
        if (w_rdLast) begin
          r_rdBank <= ~r_rdBank;
        end
      end
    end
  end

`ifdef MC_LUMA_PBUF_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  // Saturating count of dropped write beats
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dropCnt <= 8'd0;
    end else if (bus.flush_i) begin
      r_dropCnt <= 8'd0;
    end else if (w_wrReject && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  assign bus.drop_cnt_o = r_dropCnt;
`else
  assign bus.drop_cnt_o = 8'd0;
`endif

  assign bus.out_valid_o = w_rdValid;
  assign bus.out_data_o  = r_mem[w_rdAddr];
  assign bus.out_row_o   = w_rdRow;
  assign bus.out_half_o  = w_rdHalf;
  assign bus.out_last_o  = w_rdLast;
  assign bus.overflow_o  = r_overflow;

endmodule

// File: tb/tb_mc_luma_pbuf.sv
// Testbench for mc_luma_pbuf: directed macroblock writes, expected raster
// beats queued at issue time and compared by an independent monitor.
module tb_mc_luma_pbuf;

  localparam int BD = 8;
  localparam int W  = 8 * BD;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   row;
    logic         half;
    logic         last;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  mc_luma_pbuf_if #(.BIT_DEPTH(BD)) bus ();

  mc_luma_pbuf #(.BIT_DEPTH(BD)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  beat_t sb[$];
  beat_t expBeat;
  beat_t held;
  logic  stallPrev = 1'b0;
  int    checks    = 0;
  int    failures  = 0;
  int    ovfCount  = 0;
  logic  wrDone;

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Beat idx of macroblock seed: pixel k = seed*64 + idx*8 + k (mod 256)
  function automatic logic [W-1:0] beatData(input int seed, input int idx);
    logic [W-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*8 +: 8] = 8'((seed * 64 + idx * 8 + k) & 255);
    end
    return d;
  endfunction

  // Queue the 32 raster-order beats expected for one macroblock
  task automatic pushMb(input int seed);
    beat_t b;
    for (int j = 0; j < 32; j++) begin
      int y;
      int h;
      int src;
      y      = j / 2;
      h      = j % 2;
      src    = (y / 8) * 16 + h * 8 + (y % 8);
      b.data = beatData(seed, src);
      b.row  = 4'(y);
      b.half = 1'(h);
      b.last = (j == 31);
      sb.push_back(b);
    end
  endtask

  // Drive one write-port cycle
  task automatic applyStimulus(input logic wren, input logic [W-1:0] data);
    bus.mc_luma_wren_i = wren;
    bus.mc_luma_i      = data;
    @(posedge clk_i);
    #1;
  endtask

  task automatic writeMb(input int seed, input bit push, input int nBeats);
    if (push) pushMb(seed);
    for (int i = 0; i < nBeats; i++) begin
      applyStimulus(1'b1, beatData(seed, i));
    end
  endtask

  task automatic idle();
    bus.mc_luma_wren_i = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
    checkOutput({tag, "_row"},   64'(bus.out_row_o),   64'd0);
    checkOutput({tag, "_half"},  64'(bus.out_half_o),  64'd0);
    checkOutput({tag, "_last"},  64'(bus.out_last_o),  64'd0);
    checkOutput({tag, "_ovf"},   64'(bus.overflow_o),  64'd0);
    checkOutput({tag, "_drop"},  64'(bus.drop_cnt_o),  64'd0);
  endtask

  task automatic doReset(input string tag);
    bus.mc_luma_wren_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    checkResetState(tag);
  endtask

  task automatic doFlush(input string tag);
    bus.mc_luma_wren_i = 1'b0;
    bus.flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.flush_i = 1'b0;
    sb.delete();
    checkResetState(tag);
  endtask

  // Wait, bounded, until every queued beat has been observed
  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    checkOutput({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops and compares each accepted beat, checks that a stalled
  // beat holds its data and row, and counts overflow pulses
  always @(negedge clk_i) begin
    if (!rst_i && !bus.flush_i) begin
      if (stallPrev && bus.out_valid_o) begin
        checkOutput("holdData", bus.out_data_o, held.data);
        checkOutput("holdRow", 64'(bus.out_row_o), 64'(held.row));
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedBeat: got row %0d half %0d expected no beat",
                   bus.out_row_o, bus.out_half_o);
        end else begin
          expBeat = sb.pop_front();
          checkOutput("beatData", bus.out_data_o, expBeat.data);
          checkOutput("beatRow",  64'(bus.out_row_o),  64'(expBeat.row));
          checkOutput("beatHalf", 64'(bus.out_half_o), 64'(expBeat.half));
          checkOutput("beatLast", 64'(bus.out_last_o), 64'(expBeat.last));
        end
      end
      if (bus.overflow_o) ovfCount++;
      stallPrev = bus.out_valid_o && !bus.out_ready_i;
      held      = {bus.out_data_o, bus.out_row_o, bus.out_half_o, bus.out_last_o};
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  ovf0;
    bit  found;
    logic [7:0] expDrop;

    rst_i              = 1'b1;
    bus.flush_i        = 1'b0;
    bus.mc_luma_wren_i = 1'b0;
    bus.mc_luma_i      = '0;
    bus.out_ready_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkResetState("reset");

    // Single macroblock, pixel value = index, downstream always ready
    $display("[TB] single macroblock");
    bus.out_ready_i = 1'b1;
    writeMb(0, 1'b1, 31);
    checkOutput("t1ValidBefore", 64'(bus.out_valid_o), 64'd0);
    applyStimulus(1'b1, beatData(0, 31));
    idle();
    checkOutput("t1ValidAfter", 64'(bus.out_valid_o), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_i);
      if (bus.out_valid_o && bus.out_row_o == 4'd5 && bus.out_half_o) begin
        found = 1'b1;
        checkOutput("t1Row5Half1", bus.out_data_o, 64'h6F6E6D6C6B6A6968);
      end
    end
    checkOutput("t1Row5Found", 64'(found), 64'd1);
    drain("t1", 100);

    // Three macroblocks back to back, no drops expected
    $display("[TB] back-to-back macroblocks");
    ovf0 = ovfCount;
    writeMb(1, 1'b1, 32);
    writeMb(2, 1'b1, 32);
    writeMb(3, 1'b1, 32);
    idle();
    drain("t2", 300);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t2NoDrops", 64'(ovfCount - ovf0), 64'd0);
    checkOutput("t2Idle", 64'(bus.out_valid_o), 64'd0);

    // Downstream stalled: third macroblock is dropped entirely
    $display("[TB] overflow");
    doFlush("t3flush");
    bus.out_ready_i = 1'b0;
    ovf0 = ovfCount;
    writeMb(4, 1'b1, 32);
    writeMb(5, 1'b1, 32);
    writeMb(6, 1'b0, 32);
    idle();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("t3Overflows", 64'(ovfCount - ovf0), 64'd32);
`ifdef MC_LUMA_PBUF_DROP_CNT_EN
    expDrop = 8'd32;
`else
    expDrop = 8'd0;
`endif
    checkOutput("t3DropCnt", 64'(bus.drop_cnt_o), 64'(expDrop));
    checkOutput("t3Valid", 64'(bus.out_valid_o), 64'd1);
    bus.out_ready_i = 1'b1;
    drain("t3", 200);

    // First write of the next macroblock lands with the last read of bank 0
    $display("[TB] bypass write");
    doFlush("t4flush");
    bus.out_ready_i = 1'b0;
    writeMb(7, 1'b1, 32);
    writeMb(8, 1'b1, 32);
    idle();
    ovf0 = ovfCount;
    bus.out_ready_i = 1'b1;
    repeat (31) @(posedge clk_i);
    #1;
    writeMb(9, 1'b1, 32);
    idle();
    drain("t4", 300);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t4NoOverflow", 64'(ovfCount - ovf0), 64'd0);

    // Random downstream backpressure
    $display("[TB] random ready");
    doFlush("t5flush");
    wrDone = 1'b0;
    fork
      begin
        writeMb(10, 1'b1, 32);
        writeMb(11, 1'b1, 32);
        idle();
        wrDone = 1'b1;
      end
      begin
        int n;
        n = 0;
        while ((!wrDone || sb.size() != 0) && n < 3000) begin
          bus.out_ready_i = 1'($urandom_range(0, 1));
          @(posedge clk_i);
          #1;
          n++;
        end
        bus.out_ready_i = 1'b1;
      end
    join
    checkOutput("t5Drained", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("t5NoExtra", 64'(bus.out_valid_o), 64'd0);

    // Reset mid-write, reset mid-read, flush mid-write
    $display("[TB] reset and flush recovery");
    writeMb(12, 1'b0, 17);
    doReset("t6rstWr");
    bus.out_ready_i = 1'b1;
    writeMb(13, 1'b1, 32);
    idle();
    drain("t6a", 100);

    bus.out_ready_i = 1'b0;
    writeMb(14, 1'b1, 32);
    idle();
    bus.out_ready_i = 1'b1;
    repeat (9) @(posedge clk_i);
    #1;
    doReset("t6rstRd");
    writeMb(15, 1'b1, 32);
    idle();
    drain("t6b", 100);

    writeMb(16, 1'b0, 10);
    doFlush("t6flush");
    writeMb(17, 1'b1, 32);
    idle();
    drain("t6c", 100);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t6Idle", 64'(bus.out_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_luma_pbuf.md
Name: mc_luma_pbuf

Overview:
- Consumer end of the luma MC output interface. Captures the 8-pixel write beats from the luma interpolator into a ping-pong 16x16 prediction buffer.
- Replays each complete macroblock in raster order over a valid/ready stream to the residual / TQ stage.
- Decouples the interpolator's block-major write order from downstream row-major consumption.
- The write side has no backpressure, so overruns are detected and dropped.

Parameters:
- BIT_DEPTH, 8, bits per luma sample (matches the codebase `BIT_DEPTH`).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all counters and flags; storage is not cleared.
- mc_luma_wren_i  in  1  write beat valid.
- mc_luma_i  in  8*BIT_DEPTH  beat pixels.
  - [4*BD-1:0] = columns 0-3 (pixel 0 in LSBs).
  - [8*BD-1:4*BD] = columns 4-7.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  8*BIT_DEPTH  8 pixels of one half-row, pixel 0 in LSBs.
- out_row_o  out  4  MB row y, 0..15.
- out_half_o  out  1  0 = columns 0-7, 1 = columns 8-15.
- out_last_o  out  1  final beat of the MB (y=15, half=1).
- overflow_o  out  1  one-cycle pulse when a write beat is dropped.
- drop_cnt_o  out  8  dropped-beat counter (optional feature).

Behaviour:
- Storage: 2 banks x 32 entries x 8*BIT_DEPTH; register array.
  - Write address = {wr_bank, b8[1:0], r[2:0]}.
- Write order:
  - 32 beats per MB: four 8x8 sub-blocks b8 = 0..3 (0 TL, 1 TR, 2 BL, 3 BR), each 8 beats, rows r = 0..7.
  - wr_cnt[4:0] = {b8, r}, 5 bits.
- Write acceptance: a beat with mc_luma_wren_i=1 is accepted when full[wr_bank]=0, OR when the read side completes its last-beat handshake on wr_bank in the same cycle.
- Accepted beat:
  - Stores the data and increments wr_cnt.
  - At wr_cnt=31: sets full[wr_bank] and toggles wr_bank next cycle, while wr_cnt wraps to 0.
- Rejected beat: data discarded, wr_cnt unchanged, overflow_o=1 for that cycle only (registered, so it appears the cycle after the rejected beat).
- Read order: raster over the MB, rd_cnt[4:0] = {y[3:0], half}.
  - Source entry = {rd_bank, b8={y[3],half}, r=y[2:0]}.
- out_valid_o = full[rd_bank], combinational.
  - out_data_o, out_row_o, out_half_o, out_last_o come combinationally from the array and rd_cnt.
  - Stable while out_valid_o=1 and out_ready_i=0.
- Handshake: when out_valid_o & out_ready_i, rd_cnt increments.
  - On the last beat: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0.
- Simultaneous events:
  - Write-set and read-clear of the same full bit in one cycle cannot conflict: the writer only sets the bank it is filling, the reader only clears the bank it is draining.
  - A bypass-accepted first write into a bank being drained targets entry 0 while the reader holds entry {y=15, half=1}; no hazard.
- Throughput: one write and one read beat per cycle, sustained, with both banks ping-ponging.
- Reset or flush, including mid-MB or mid-read:
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full=2'b00.
  - out_valid_o=0, overflow_o=0, drop_cnt_o=0.
  - Partial MBs are abandoned.
  - out_data_o is X-free only after the first write (storage is not reset).

Optional Feature:
- Macro MC_LUMA_PBUF_DROP_CNT_EN.
- Defined: drop_cnt_o is an 8-bit counter incremented on each rejected beat. It saturates at 255 and is cleared by rst_i or flush_i.
- Undefined: no counter logic; drop_cnt_o tied to 8'd0. overflow_o behaviour is unchanged.

Test Plan:
- Single MB written in 32 consecutive beats, pixel value = index, with out_ready_i=1 → out_valid_o rises the cycle after beat 31 and 32 beats follow.
  - Row y=5, half=1 equals the sub-block 1, r=5 beat.
  - out_last_o asserts only at beat 32.
- Back-to-back 3 MBs with out_ready_i=1 → zero drops; banks alternate 0,1,0; every output beat matches the reference reorder.
- out_ready_i=0 while 2 MBs are written, then a 3rd MB starts → all 32 beats rejected, overflow_o pulses 32 times, drop_cnt_o=32 (macro on) or 0 (off).
  - Releasing ready then outputs MB0 then MB1 intact.
- Read last-beat handshake on bank 0 in the same cycle as the first write of the next MB to bank 0 → write accepted, no overflow, and bank 0's new data matches when read.
- Random out_ready_i toggling at 50% → out_data_o and out_row_o hold while stalled, and no beat is lost or duplicated.
- rst_i asserted at write beat 17 and again mid-read (beat 9), plus flush_i → all outputs are 0 the next cycle, and a fresh MB afterwards reads back correctly from bank 0.
